vc_requester: RTL

Transmit-side requester for the eight-channel PCIe virtual-channel arbiter. It queues packet descriptors per virtual channel, drives the arbiter's 8-bit request vector, accepts the arbiter's one-hot grant, and streams the granted packet out beat by beat. Sits between the transaction-layer packet source and the arbiter, and owns the request/grant pair from the requesting end.

---
 rtl/vc_requester.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vc_requester.sv
// vc_requester: transmit-side requester for the eight-channel VC arbiter.
// It keeps a descriptor FIFO for each VC, drives the request vector and
// takes the arbiter's one-hot grant. It then streams the granted packet
// out one beat per cycle, followed by a single gap cycle.
// Optional feature macro: VC_REQ_GNT_CHECK_EN adds a sticky err output
// that flags malformed or unrequested grants.
//
// state | meaning
// IDLE  | requesting every non-empty VC, waiting for a valid grant
// SEND  | streaming beats 0..len of the granted packet
// GAP   | one idle cycle after the last beat, requests held low
module vc_requester #(
  parameter  int NVC   = 8,
  parameter  int DEPTH = 4,
  parameter  int LENW  = 4,
  localparam int VCW   = $clog2(NVC)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            push,
  input  logic [VCW-1:0]  push_vc,
  input  logic [LENW-1:0] push_len,
  output logic            push_ready,
  output logic [NVC-1:0]  req,
  input  logic [NVC-1:0]  id,
  output logic            tx_valid,
  output logic [VCW-1:0]  tx_vc,
  output logic [LENW-1:0] tx_beat,
  output logic            tx_last
`ifdef VC_REQ_GNT_CHECK_EN
  ,
  output logic            err
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state_q, state_d;
  logic [VCW-1:0]  tx_vc_q, tx_vc_d;
  logic [LENW-1:0] beat_q, beat_d;
  logic [LENW-1:0] len_q, len_d;

  logic [LENW-1:0] mem_q [NVC][DEPTH];
  logic [LENW-1:0] mem_d [NVC][DEPTH];
  logic [PW-1:0]   wr_ptr_q [NVC];
  logic [PW-1:0]   wr_ptr_d [NVC];
  logic [PW-1:0]   rd_ptr_q [NVC];
  logic [PW-1:0]   rd_ptr_d [NVC];
  logic [CW-1:0]   cnt_q [NVC];
  logic [CW-1:0]   cnt_d [NVC];

  logic [NVC-1:0]  nonempty;
  logic [NVC-1:0]  req_int;
  logic            gnt_onehot;
  logic            gnt_hit;
  logic            gnt_ok;
  logic [VCW-1:0]  gnt_idx;
  logic            push_ok;
  logic            pop;

  // Request mask and grant qualification; req depends only on registered state.
  always_comb begin
    nonempty = '0;
    gnt_idx  = '0;
    for (int v = 0; v < NVC; v++) begin
      nonempty[v] = (cnt_q[v] != '0);
      if (id[v]) gnt_idx = VCW'(v);
    end
    req_int    = (state_q == IDLE) ? nonempty : '0;
    gnt_onehot = (id != '0) && ((id & (id - NVC'(1))) == '0);
    gnt_hit    = |(id & req_int);
    gnt_ok     = (state_q == IDLE) && gnt_onehot && gnt_hit;
    push_ready = (cnt_q[push_vc] < CW'(DEPTH));
    push_ok    = push && push_ready;
  end

  assign req      = req_int;
  assign tx_valid = (state_q == SEND);
  assign tx_vc    = tx_vc_q;
  assign tx_beat  = beat_q;
  assign tx_last  = (state_q == SEND) && (beat_q == len_q);

  // Next-state logic: FSM transitions, grant pop and per-VC FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    tx_vc_d  = tx_vc_q;
    beat_d   = beat_q;
    len_d    = len_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_ok) begin
          state_d = SEND;
          tx_vc_d = gnt_idx;
          len_d   = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
          beat_d  = '0;
          pop     = 1'b1;
        end
      end
      SEND: begin
        if (beat_q == len_q) state_d = GAP;
        else                 beat_d  = beat_q + LENW'(1);
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A push and a pop on the same VC can happen together. A full VC never
    // accepts a push, because push_ready is based on the registered count.
    for (int v = 0; v < NVC; v++) begin
      logic push_v;
      logic pop_v;
      push_v = push_ok && (push_vc == VCW'(v));
      pop_v  = pop && (gnt_idx == VCW'(v));
      if (push_v) begin
        mem_d[v][wr_ptr_q[v]] = push_len;
        wr_ptr_d[v] = (wr_ptr_q[v] == PW'(DEPTH - 1)) ? '0 : wr_ptr_q[v] + PW'(1);
      end
      if (pop_v) begin
        rd_ptr_d[v] = (rd_ptr_q[v] == PW'(DEPTH - 1)) ? '0 : rd_ptr_q[v] + PW'(1);
      end
      cnt_d[v] = cnt_q[v] + CW'(push_v) - CW'(pop_v);
    end
  end

  // State, packet and FIFO registers; reset aborts any packet and drops all queues.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      tx_vc_q <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      for (int v = 0; v < NVC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
        for (int d = 0; d < DEPTH; d++) mem_q[v][d] <= '0;
      end
    end else begin
      state_q  <= state_d;
      tx_vc_q  <= tx_vc_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

`ifdef VC_REQ_GNT_CHECK_EN
  logic err_q, err_d;
  logic err_set;

  // Sticky flag for a multi-hot grant, or a grant on a VC that is not requesting.
  always_comb begin
    err_set = (state_q == IDLE) &&
              (((id != '0) && !gnt_onehot) || (gnt_onehot && !gnt_hit));
    err_d   = err_q | err_set;
  end

  // Error register; it is cleared only by reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
